etapa_busqueda: RTL
===================

# etapa_busqueda

Instruction-fetch stage of the segmented processor: holds the PC, drives the instruction-memory address, selects the next PC (sequential, branch/jump redirect, optional early jump), and owns the IF/ID pipeline register. Its `if_id_imm16` output feeds the `instr` port of the decode-stage sign extender (`extencion_signo`), whose 32-bit `oinstr` goes on to ID/EX. Stall and flush come from the hazard unit and the branch-resolution logic in decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0000, encoding inserted into IF/ID for bubbles (sll $0,$0,0)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_addr`  out  32  word address to instruction memory (= PC)
- `imem_data`  in  32  instruction read combinationally from `imem_addr`
- `imem_ready`  in  1  `imem_data` valid this cycle
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `redirect`  in  1  taken branch/jump resolved in decode
- `redirect_pc`  in  32  target for `redirect`
- `pc_out`  out  32  current PC (debug/trace)
- `if_id_instr`  out  32  registered instruction
- `if_id_pc4`  out  32  registered PC+4 of that instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_imm16`  out  16  `if_id_instr[15:0]`, to sign extender

## Operation
- Reset (`rst_n`=0, async): PC=`RESET_PC`, `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0, `if_id_valid`=0. `imem_addr`/`pc_out` track PC, so they read `RESET_PC` during reset.
- Per-edge priority, highest first:
  1. `redirect`: PC←`redirect_pc`; IF/ID←bubble (`NOP_INSTR`, valid 0, pc4 0). Overrides `stall` and `imem_ready`=0.
  2. `stall`: PC and IF/ID hold unchanged.
  3. `imem_ready`=0: PC holds; IF/ID←bubble.
  4. Normal: IF/ID←{`imem_data`, PC+4, valid 1}; PC←next_pc.
- next_pc = PC+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), except early jump (see Configuration).
- PC[1:0] is always 0. `redirect_pc[1:0]` is ignored and forced to 0.
- Bubbles are architecturally inert: downstream qualifies with `if_id_valid`.
- No internal FSM beyond the PC/IF/ID registers. Fetch state is implied by {valid, stall, redirect}.

## Timing
- Fetch latency is 1 cycle: the instruction at PC appears on `if_id_*` after the next rising edge.
- Redirect penalty is 1 bubble. The target instruction reaches IF/ID 2 edges after `redirect` is sampled.
- Stall is cycle-exact: N stall cycles hold IF/ID for N edges. The instruction already in IF/ID is not lost.
- `redirect` asserted during a stall is taken immediately, not deferred.
- Reset deassertion is synchronised externally. The first fetch of `RESET_PC` occurs on the first edge with `rst_n`=1.

## Configuration
- `FETCH_JUMP_EN` defined:
  - When a normal fetch captures `imem_data[31:26]`=6'b000010 (j), next_pc = {(PC+4)[31:28], imem_data[25:0], 2'b00}, giving a zero-bubble `j`.
  - The `j` still enters IF/ID with valid 1. Decode must not also assert `redirect` for it.
  - `jal` is not early-resolved.
  - A redirect in the same cycle wins and the jump is discarded.
- `FETCH_JUMP_EN` undefined: next_pc is always PC+4, and every jump is resolved via `redirect`.

## Structure
- Shared package `procesador_pkg`: `OP_J`=6'b000010, `NOP_INSTR` default, `RESET_PC` default, instruction field slice widths (opcode 6, target 26, imm 16).
- One sub-module, `registro_if_id`, implements the IF/ID register with load/hold/bubble control. PC register and next-PC mux stay in the top.

## Test plan
- Reset then free-run with `imem_ready`=1, memory returning 32'h2008_0005 at 0 and 32'h2009_FFFF at 4:
  - edge 1: IF/ID = {32'h2008_0005, pc4=4, valid=1};
  - edge 2: IF/ID = {32'h2009_FFFF, pc4=8}, `if_id_imm16`=16'hFFFF.
- Stall for 3 cycles at PC=8: PC stays 8 and IF/ID stays unchanged for 3 edges; fetch resumes from 8.
- `redirect`=1, `redirect_pc`=32'h0000_0040, together with `stall`=1: next edge PC=0x40, IF/ID valid=0 with `NOP_INSTR`; the following edge holds instr@0x40 with pc4=0x44.
- `imem_ready`=0 for 2 cycles: PC holds; 2 bubbles (valid 0) appear in IF/ID.
- PC=32'hFFFF_FFFC, normal fetch: next PC=0, `if_id_pc4`=0.
- With `FETCH_JUMP_EN`, fetch 32'h0800_0010 at PC=0x100: next PC=0x40 with no bubble. Without the macro, next PC=0x104.

Source files
------------

// File: rtl/etapa_busqueda_pkg.sv
// ---------------------------------------------------------------------------
// procesador_pkg: definitions shared by the segmented processor stages.
//   - instruction field widths and the j opcode
//   - reset PC and the bubble (nop) encoding
//   - if_id_t: contents of the IF/ID pipeline register
// ---------------------------------------------------------------------------
package procesador_pkg;

    localparam int OPC_W = 6;
    localparam int TGT_W = 26;
    localparam int IMM_W = 16;

    localparam logic [OPC_W-1:0] OP_J      = 6'b000010;
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0]      RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/etapa_busqueda_if.sv
// ---------------------------------------------------------------------------
// etapa_busqueda_if: instruction-memory bus between fetch and imem.
//   imem_addr  : word address (fetch -> memory)
//   imem_data  : instruction read combinationally from imem_addr
//   imem_ready : imem_data valid this cycle
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface etapa_busqueda_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;

    modport master (output imem_addr, input imem_data, input imem_ready);
    modport slave  (input imem_addr, output imem_data, output imem_ready);

endinterface

// File: rtl/etapa_busqueda_registro_if_id.sv
// ---------------------------------------------------------------------------
// registro_if_id: IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (resets to a bubble)
//   load       : capture d
//   bubble     : insert a bubble; wins over load
//   d / q      : register contents (instr, pc4, valid)
// Neither load nor bubble -> hold (stall).
// ---------------------------------------------------------------------------
module registro_if_id
    import procesador_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q <= IF_ID_BUBBLE;
        else if (bubble) q <= IF_ID_BUBBLE;
        else if (load)   q <= d;
    end

endmodule

// File: rtl/etapa_busqueda.sv
// ---------------------------------------------------------------------------
// etapa_busqueda: instruction-fetch stage.
//   clk, rst_n   : clock, async active-low reset
//   imem         : instruction-memory bus (master side)
//   stall        : hold PC and IF/ID
//   redirect     : taken branch/jump from decode, target in redirect_pc
//   pc_out       : current PC
//   if_id_*      : IF/ID register outputs; if_id_imm16 feeds the sign extender
// Optional feature: define FETCH_JUMP_EN to resolve `j` at fetch with no bubble.
// Edge priority: redirect > stall > !imem_ready (bubble) > normal fetch.
// ---------------------------------------------------------------------------
module etapa_busqueda
    import procesador_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    etapa_busqueda_if.master        imem,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic [31:0]             pc_out,
    output logic [31:0]             if_id_instr,
    output logic [31:0]             if_id_pc4,
    output logic                    if_id_valid,
    output logic [IMM_W-1:0]        if_id_imm16
);

    logic [31:0] pc, pc4, next_pc;
    logic        fetch;
    if_id_t      if_id_d, if_id_q;

    assign pc4   = pc + 32'd4;               // wraps naturally at 2^32
    assign fetch = !redirect && !stall && imem.imem_ready;

`ifdef FETCH_JUMP_EN
    // Early j: target built from the instruction being fetched right now.
    always_comb begin
        next_pc = pc4;
        if (imem.imem_data[31:32-OPC_W] == OP_J)
            next_pc = {pc4[31:28], imem.imem_data[TGT_W-1:0], 2'b00};
    end
`else
    assign next_pc = pc4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= RESET_PC;
        else if (redirect) pc <= {redirect_pc[31:2], 2'b00};
        else if (fetch)    pc <= next_pc;
    end

    assign if_id_d = '{instr: imem.imem_data, pc4: pc4, valid: 1'b1};

    registro_if_id u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (fetch),
        .bubble (redirect || (!stall && !imem.imem_ready)),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign imem.imem_addr = pc;
    assign pc_out         = pc;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc4      = if_id_q.pc4;
    assign if_id_valid    = if_id_q.valid;
    assign if_id_imm16    = if_id_q.instr[IMM_W-1:0];

endmodule
